// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants and state encoding for the bit-serial adder
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - combinational one-bit full adder cell
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | ((a ^ b) & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences one full-adder cell over WIDTH cycles for add/sub
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_co;

  fa_bit u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sh_d    = {fa_s, sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Outputs are loaded on the edge entering DONE so they line up with done.
          result_d = {fa_s, sh_q[WIDTH-1:1]};
          cout_d   = fa_co;
          ovf_d    = carry_q ^ fa_co;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  exp_t         expq[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_res = '0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as unsigned and signed values.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    exp_t e;
    int ua, ub, sa, sb, full, sv;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (!ts) begin
      full = ua + ub;
      sv   = sa + sb;
      e.c  = (full > 255);
    end else begin
      full = ua - ub;
      sv   = sa - sb;
      e.c  = (ua >= ub);
    end
    e.r = W'(full);
    e.o = (sv > 127) || (sv < -128);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("result", result, e.r);
        check("cout", cout, e.c);
        check("ovf", ovf, e.o);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  // One operation with per-cycle busy/done/hold checks; inject_k>0 pulses start mid-RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input int inject_k);
    exp_t e;
    wait_idle();
    a = ta; b = tb; sub = ts; start = 1'b1;
    e = model(ta, tb, ts);
    expq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == inject_k) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      check("busy", busy, (k <= 9));
      check("done", done, (k == 9));
      if (k <= 8) check("result_hold", result, last_res);
    end
    last_res = e.r;
  endtask

  initial begin
    int last_done;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);

    run_op(8'h3C, 8'h42, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h05, 8'h07, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b1, 0);
    run_op(8'h10, 8'h20, 1'b0, 3);

    // start held high: one op accepted per IDLE cycle
    wait_idle();
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    expq.push_back(model(8'h01, 8'h01, 1'b0));
    last_done = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (last_done >= 0) check("done_period", i - last_done, 10);
        last_done = i;
      end
      if (i == 30) start = 1'b0;
      else if (!busy) expq.push_back(model(8'h01, 8'h01, 1'b0));
    end
    check("held_saw_done", (last_done >= 0), 1);
    last_res = 8'h02;

    // reset during RUN abandons the op
    wait_idle();
    for (int i = 0; i < 12 && expq.size() != 0; i++) @(negedge clk);
    wait_idle();
    a = 8'h55; b = 8'h11; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    repeat (12) @(negedge clk);
    last_res = '0;
    run_op(8'h12, 8'h34, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
    end

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
